// File: rtl/uart_tx_fifo_if.sv
// Valid/ready write port carrying words from the producer into the UART transmit FIFO.
interface uart_tx_fifo_if #(
    parameter int unsigned DATA_BITS = 8
) ();
    logic                 s_valid;
    logic [DATA_BITS-1:0] s_data;
    logic                 s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small word FIFO; frame format and bit period are latched
// per frame when the head word is popped.
module uart_tx_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_W      = 16,
    localparam int unsigned LvlW = $clog2(FIFO_DEPTH + 1),
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int unsigned BitW = $clog2(DATA_BITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] clks_per_bit,
    input  logic [1:0]       parity_mode,
    input  logic             two_stop,
    uart_tx_fifo_if.slave    s_if,
    output logic             tx,
    output logic             busy,
    output logic [LvlW-1:0]  fifo_level
);
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]      level_q, level_d;
    state_e               state_q, state_d;
    logic [DIV_W-1:0]     baud_q, baud_d, div_q, div_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_en_q, par_en_d, par_bit_q, par_bit_d;
    logic                 two_stop_q, two_stop_d, tx_q, tx_d;
    logic                 push, pop, baud_end, fifo_nempty;
    logic [DATA_BITS-1:0] head;

    assign fifo_nempty = (level_q != '0);
    assign head        = mem_q[rd_ptr_q];
    assign s_if.s_ready = (level_q < LvlW'(FIFO_DEPTH));
    assign push        = s_if.s_valid && s_if.s_ready;
    assign baud_end    = (baud_q == div_q - DIV_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            state_q    <= StIdle;
            baud_q     <= '0;
            div_q      <= DIV_W'(2);
            bit_q      <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_if.s_data;
        end
    end

    // Next-state logic: frame sequencing and FIFO bookkeeping
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        div_d      = div_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        pop        = 1'b0;

        if (state_q != StIdle) begin
            baud_d = baud_end ? '0 : baud_q + DIV_W'(1);
        end

        case (state_q)
            StIdle: pop = fifo_nempty;
            StStart: begin
                if (baud_end) begin
                    state_d = StData;
                    bit_d   = '0;
                end
            end
            StData: begin
                if (baud_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BitW'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = par_en_q ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end
            end
            StParity: begin
                if (baud_end) state_d = StStop;
            end
            StStop: begin
                if (baud_end) begin
                    // bit_q counts completed stop periods when two are requested
                    if (two_stop_q && bit_q == '0) begin
                        bit_d = BitW'(1);
                    end else if (fifo_nempty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (pop) begin
            state_d    = StStart;
            baud_d     = '0;
            bit_d      = '0;
            shift_d    = head;
            div_d      = (clks_per_bit < DIV_W'(2)) ? DIV_W'(2) : clks_per_bit;
            par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
            par_bit_d  = (^head) ^ (parity_mode == 2'b10);
            two_stop_d = two_stop;
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    // Output logic: tx is registered from the upcoming state so it moves on bit boundaries only
    always_comb begin
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = par_bit_d;
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx         = tx_q;
    assign busy       = (state_q != StIdle) || fifo_nempty;
    assign fifo_level = level_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame shapes, parity, FIFO back-pressure, config latching,
// mid-frame reset and minimum bit period.
module tb_uart_tx_fifo;
    logic        clk;
    logic        rst_n;
    logic [15:0] clks_per_bit;
    logic [1:0]  parity_mode;
    logic        two_stop;
    logic        tx;
    logic        busy;
    logic [2:0]  fifo_level;

    int n_checks;
    int n_pass;
    logic cap [512];
    logic bsy [512];

    uart_tx_fifo_if #(.DATA_BITS(8)) s_if ();

    uart_tx_fifo #(
        .DATA_BITS  (8),
        .FIFO_DEPTH (4),
        .DIV_W      (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clks_per_bit (clks_per_bit),
        .parity_mode  (parity_mode),
        .two_stop     (two_stop),
        .s_if         (s_if),
        .tx           (tx),
        .busy         (busy),
        .fifo_level   (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word is pushed on the next edge; returns 1ns after that edge.
    task automatic push_one(input logic [7:0] w);
        s_if.s_valid = 1'b1;
        s_if.s_data  = w;
        @(posedge clk);
        #1;
        s_if.s_valid = 1'b0;
    endtask

    // Record tx/busy for n cycles, one sample 1ns after each edge.
    task automatic capture(input int base, input int n);
        for (int c = 0; c < n; c++) begin
            cap[base + c] = tx;
            bsy[base + c] = busy;
            @(posedge clk);
            #1;
        end
    endtask

    // Number of captured cycles disagreeing with bit sequence 'bits' (bit 0 sent first).
    function automatic int frame_diff(input int start, input int nbits, input int div,
                                      input logic [63:0] bits);
        int bad = 0;
        for (int i = 0; i < nbits * div; i++) begin
            if (cap[start + i] !== bits[i / div]) bad++;
        end
        return bad;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        clks_per_bit = 16'd4;
        parity_mode  = 2'b00;
        two_stop     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++;
        if (fifo_level !== 3'd0) $display("FAIL reset_level: got %0d want 0", fifo_level);
        else n_pass++;
        n_checks++;
        if (s_if.s_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", s_if.s_ready);
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_frame();
        int d;
        clks_per_bit = 16'd4;
        parity_mode  = 2'b00;
        two_stop     = 1'b0;
        push_one(8'hA5);
        capture(0, 41);
        d = frame_diff(1, 10, 4, 64'b1101001010);
        n_checks++;
        if (d !== 0) $display("FAIL basic_frame: %0d cycles wrong, want 0", d); else n_pass++;
        n_checks++;
        if (bsy[40] !== 1'b1) $display("FAIL basic_busy_last: got %b want 1", bsy[40]);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", busy); else n_pass++;
        n_checks++;
        if (tx !== 1'b1) $display("FAIL basic_tx_idle: got %b want 1", tx); else n_pass++;
    endtask

    task automatic test_parity();
        int d;
        clks_per_bit = 16'd4;
        parity_mode  = 2'b01;
        two_stop     = 1'b1;
        push_one(8'h07);
        capture(0, 49);
        d = frame_diff(1, 12, 4, 64'b111000001110);
        n_checks++;
        if (d !== 0) $display("FAIL even_two_stop_frame: %0d cycles wrong, want 0", d);
        else n_pass++;
        n_checks++;
        if (bsy[48] !== 1'b1 || busy !== 1'b0)
            $display("FAIL even_frame_len: busy@48=%b busy@49=%b want 1,0", bsy[48], busy);
        else n_pass++;

        parity_mode = 2'b10;
        two_stop    = 1'b0;
        push_one(8'h07);
        capture(0, 45);
        d = frame_diff(1, 11, 4, 64'b10000001110);
        n_checks++;
        if (d !== 0) $display("FAIL odd_frame: %0d cycles wrong, want 0", d); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL odd_busy_end: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] w [6];
        int idx, acc5, d, max_lvl, busy_drop;
        bit saw_full, acc;
        w = '{8'h3C, 8'h81, 8'h5A, 8'hF0, 8'h0F, 8'h96};
        clks_per_bit = 16'd2;
        parity_mode  = 2'b00;
        two_stop     = 1'b0;
        idx = 0; acc5 = -1; max_lvl = 0; saw_full = 1'b0; busy_drop = 0;
        s_if.s_valid = 1'b1;
        s_if.s_data  = w[0];
        for (int c = 0; c < 125; c++) begin
            acc = s_if.s_valid && s_if.s_ready;
            if (fifo_level == 3'd4 && !s_if.s_ready) saw_full = 1'b1;
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
            @(posedge clk);
            #1;
            if (acc) begin
                if (idx == 5) acc5 = c;
                idx++;
                if (idx < 6) s_if.s_data = w[idx];
                else s_if.s_valid = 1'b0;
            end
            cap[c] = tx;
            bsy[c] = busy;
        end
        d = 0;
        for (int f = 0; f < 6; f++) d += frame_diff(1 + f * 20, 10, 2, {1'b1, w[f], 1'b0});
        for (int c = 0; c <= 120; c++) if (bsy[c] !== 1'b1) busy_drop++;
        n_checks++;
        if (!saw_full) $display("FAIL b2b_full_stall: level=4 with s_ready low never seen");
        else n_pass++;
        n_checks++;
        if (max_lvl !== 4) $display("FAIL b2b_max_level: got %0d want 4", max_lvl); else n_pass++;
        n_checks++;
        if (acc5 !== 22) $display("FAIL b2b_sixth_accept: cycle %0d want 22", acc5); else n_pass++;
        n_checks++;
        if (d !== 0) $display("FAIL b2b_frames: %0d cycles wrong, want 0", d); else n_pass++;
        n_checks++;
        if (busy_drop !== 0 || bsy[121] !== 1'b0)
            $display("FAIL b2b_busy: drops=%0d end=%b want 0,0", busy_drop, bsy[121]);
        else n_pass++;
    endtask

    task automatic test_config_latch();
        int d0, d1;
        clks_per_bit = 16'd4;
        parity_mode  = 2'b00;
        two_stop     = 1'b0;
        push_one(8'hC6);
        push_one(8'h39);
        capture(0, 10);
        clks_per_bit = 16'd8;
        capture(10, 111);
        d0 = frame_diff(0, 10, 4, {1'b1, 8'hC6, 1'b0});
        d1 = frame_diff(40, 10, 8, {1'b1, 8'h39, 1'b0});
        n_checks++;
        if (d0 !== 0) $display("FAIL cfg_frame_div4: %0d cycles wrong, want 0", d0); else n_pass++;
        n_checks++;
        if (d1 !== 0) $display("FAIL cfg_frame_div8: %0d cycles wrong, want 0", d1); else n_pass++;
        n_checks++;
        if (bsy[119] !== 1'b1 || bsy[120] !== 1'b0)
            $display("FAIL cfg_busy_end: busy@119=%b busy@120=%b want 1,0", bsy[119], bsy[120]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int d, busy_high;
        clks_per_bit = 16'd4;
        parity_mode  = 2'b00;
        two_stop     = 1'b0;
        push_one(8'hA5);
        push_one(8'h11);
        capture(0, 17);
        n_checks++;
        if (tx !== 1'b0 || fifo_level !== 3'd1)
            $display("FAIL rst_pre: tx=%b level=%0d want 0,1", tx, fifo_level);
        else n_pass++;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (tx !== 1'b1) $display("FAIL rst_mid_tx: got %b want 1", tx); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else n_pass++;
        n_checks++;
        if (fifo_level !== 3'd0) $display("FAIL rst_mid_level: got %0d want 0", fifo_level);
        else n_pass++;
        n_checks++;
        if (s_if.s_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", s_if.s_ready);
        else n_pass++;
        rst_n = 1'b1;
        capture(0, 30);
        d = frame_diff(0, 30, 1, 64'hFFFF_FFFF);
        busy_high = 0;
        for (int c = 0; c < 30; c++) if (bsy[c] !== 1'b0) busy_high++;
        n_checks++;
        if (d !== 0 || busy_high !== 0)
            $display("FAIL rst_no_resume: tx_low=%0d busy_high=%0d want 0,0", d, busy_high);
        else n_pass++;
    endtask

    task automatic test_min_div();
        int d;
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        clks_per_bit = 16'd0;
        push_one(8'h5A);
        capture(0, 21);
        d = frame_diff(1, 10, 2, {1'b1, 8'h5A, 1'b0});
        n_checks++;
        if (d !== 0) $display("FAIL div0_frame: %0d cycles wrong, want 0", d); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL div0_busy_end: got %b want 0", busy); else n_pass++;

        clks_per_bit = 16'd1;
        push_one(8'hC3);
        capture(0, 21);
        d = frame_diff(1, 10, 2, {1'b1, 8'hC3, 1'b0});
        n_checks++;
        if (d !== 0) $display("FAIL div1_frame: %0d cycles wrong, want 0", d); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL div1_busy_end: got %b want 0", busy); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_basic_frame();
        test_parity();
        test_back_to_back();
        test_config_latch();
        test_reset_mid_frame();
        test_min_div();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
